debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_pkg.sv | 16 +
 rtl/debounce_chan.sv | 84 ++++++++
 rtl/debounce_bank.sv | 47 ++++
 tb/tb_debounce_bank.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the button debounce bank.
// Holds default lock-out/hold periods and the clog2 width function.
package debounce_pkg;

    localparam int DEF_TIME_PERIOD = 75000;
    localparam int DEF_LONG_PERIOD = 1500000;

    // Bits needed to hold values 0..v-1, never less than 1.
    function automatic int clog2w(input int v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop sync, lock-out, edge pulses, long-press.
// Ports: i_clk, i_reset_n, i_btn (raw pin) -> o_debounced, o_press,
//        o_release, o_long (all 1 bit, active-high, registered).
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   TIME_PERIOD = DEF_TIME_PERIOD,
    parameter int   LONG_PERIOD = DEF_LONG_PERIOD,
    parameter logic ACTIVE_LOW  = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_btn,
    output logic o_debounced,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int LW = clog2w(TIME_PERIOD);
    localparam int HW = clog2w(LONG_PERIOD + 1);

    localparam logic [LW-1:0] LOAD = LW'(TIME_PERIOD - 1);
    localparam logic [HW-1:0] HMAX = HW'(LONG_PERIOD);
    localparam logic [HW-1:0] HPRE = HW'(LONG_PERIOD - 1);

    logic          s1;
    logic          s2;
    logic          db_q;
    logic [LW-1:0] lock;
    logic [HW-1:0] hold;

    // Polarity is corrected before the synchronizer.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= i_btn ^ ACTIVE_LOW;
            s2 <= s1;
        end
    end

    // Accept a change only when idle; then ignore input for the period.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_debounced <= 1'b0;
            lock        <= '0;
        end else if (lock != '0) begin
            lock <= lock - 1'b1;
        end else if (s2 != o_debounced) begin
            o_debounced <= s2;
            lock        <= LOAD;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            db_q      <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            db_q      <= o_debounced;
            o_press   <= o_debounced & ~db_q;
            o_release <= ~o_debounced & db_q;
        end
    end

    // Saturating hold counter; the pulse fires on the step into HMAX.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold   <= '0;
            o_long <= 1'b0;
        end else begin
            if (!o_debounced) begin
                hold <= '0;
            end else if (hold != HMAX) begin
                hold <= hold + 1'b1;
            end
            o_long <= o_debounced && (hold == HPRE);
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Bank of NCH independent debounced button channels.
// Ports: i_clk, i_reset_n, i_btn[NCH] -> o_debounced, o_press,
//        o_release, o_long (each NCH bits, bit k belongs to channel k).
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int             NCH         = 4,
    parameter int             TIME_PERIOD = DEF_TIME_PERIOD,
    parameter int             LONG_PERIOD = DEF_LONG_PERIOD,
    parameter logic [NCH-1:0] ACTIVE_LOW  = {NCH{1'b0}}
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic [NCH-1:0] i_btn,
    output logic [NCH-1:0] o_debounced,
    output logic [NCH-1:0] o_press,
    output logic [NCH-1:0] o_release,
    output logic [NCH-1:0] o_long
);

    if (NCH < 1 || NCH > 32) begin : g_bad_nch
        $error("debounce_bank: NCH out of range");
    end
    if (TIME_PERIOD < 2) begin : g_bad_tp
        $error("debounce_bank: TIME_PERIOD too small");
    end
    if (LONG_PERIOD <= TIME_PERIOD) begin : g_bad_lp
        $error("debounce_bank: LONG_PERIOD must exceed TIME_PERIOD");
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        debounce_chan #(
            .TIME_PERIOD (TIME_PERIOD),
            .LONG_PERIOD (LONG_PERIOD),
            .ACTIVE_LOW  (ACTIVE_LOW[k])
        ) u_chan (
            .i_clk       (i_clk),
            .i_reset_n   (i_reset_n),
            .i_btn       (i_btn[k]),
            .o_debounced (o_debounced[k]),
            .o_press     (o_press[k]),
            .o_release   (o_release[k]),
            .o_long      (o_long[k])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank.
// NCH=2, TIME_PERIOD=8, LONG_PERIOD=20, ACTIVE_LOW=2'b10.
module tb_debounce_bank;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic [1:0] i_btn;
    logic [1:0] o_debounced;
    logic [1:0] o_press;
    logic [1:0] o_release;
    logic [1:0] o_long;

    int n_cmp = 0;
    int n_err = 0;

    debounce_bank #(
        .NCH         (2),
        .TIME_PERIOD (8),
        .LONG_PERIOD (20),
        .ACTIVE_LOW  (2'b10)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_btn       (i_btn),
        .o_debounced (o_debounced),
        .o_press     (o_press),
        .o_release   (o_release),
        .o_long      (o_long)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // exp = {debounced, press, release, long}
    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {o_debounced, o_press, o_release, o_long};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int np, nr, nl;
    logic bad;

    initial begin
        // Reset with both channels idle (ch1 idle pin level is 1).
        i_reset_n = 1'b0;
        i_btn     = 2'b10;
        tick();
        tick();
        chk("reset", 8'b00_00_00_00);
        i_reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_reset_idle", 8'b00_00_00_00);
        end

        // Clean press on ch0, held 30 cycles, then release.
        i_btn = 2'b11;
        tick();
        tick();
        chk("press_t2", 8'b00_00_00_00);
        tick();
        chk("press_t3", 8'b01_00_00_00);
        tick();
        chk("press_t4", 8'b01_01_00_00);
        tick();
        chk("press_t5", 8'b01_00_00_00);
        bad = 1'b0;
        for (int k = 6; k <= 22; k++) begin
            tick();
            if ({o_debounced, o_press, o_release, o_long} != 8'b01_00_00_00)
                bad = 1'b1;
        end
        chk_n("hold_quiet", int'(bad), 0);
        tick();
        chk("long_t23", 8'b01_00_00_01);
        tick();
        chk("long_t24", 8'b01_00_00_00);
        for (int k = 25; k <= 30; k++) tick();
        chk("held_t30", 8'b01_00_00_00);
        i_btn = 2'b10;
        tick();
        tick();
        chk("rel_t2", 8'b01_00_00_00);
        tick();
        chk("rel_t3", 8'b00_00_00_00);
        tick();
        chk("rel_t4", 8'b00_00_01_00);
        tick();
        chk("rel_t5", 8'b00_00_00_00);
        for (int k = 0; k < 12; k++) tick();

        // Short hold of 15 cycles: no long pulse.
        np = 0; nr = 0; nl = 0;
        i_btn = 2'b11;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 15) i_btn = 2'b10;
            np += int'(o_press[0]);
            nr += int'(o_release[0]);
            nl += int'(o_long[0]);
        end
        chk_n("short_press_cnt", np, 1);
        chk_n("short_rel_cnt", nr, 1);
        chk_n("short_long_cnt", nl, 0);

        // Bouncing edge: toggles every cycle for 6 cycles, settles high.
        np = 0; nr = 0; bad = 1'b0;
        i_btn = 2'b11;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k <= 6) i_btn[0] = ~i_btn[0];
            if (k >= 3 && o_debounced[0] !== 1'b1) bad = 1'b1;
            np += int'(o_press[0]);
            nr += int'(o_release[0]);
        end
        chk_n("bounce_press_cnt", np, 1);
        chk_n("bounce_rel_cnt", nr, 0);
        chk_n("bounce_stable", int'(bad), 0);
        chk("bounce_end", 8'b01_00_00_00);
        i_btn = 2'b10;
        for (int k = 0; k < 15; k++) tick();
        chk("bounce_released", 8'b00_00_00_00);

        // Simultaneous press on ch0 (high) and ch1 (active-low).
        i_btn = 2'b01;
        tick();
        tick();
        chk("sim_t2", 8'b00_00_00_00);
        tick();
        chk("sim_t3", 8'b11_00_00_00);
        tick();
        chk("sim_t4", 8'b11_11_00_00);
        for (int k = 5; k <= 10; k++) tick();
        i_btn = 2'b10;
        tick();
        tick();
        tick();
        chk("sim_rel_t3", 8'b00_00_00_00);
        tick();
        chk("sim_rel_t4", 8'b00_00_11_00);
        tick();
        chk("sim_rel_t5", 8'b00_00_00_00);
        for (int k = 0; k < 12; k++) tick();

        // Reset in the middle of lock-out (counter at 4).
        i_btn = 2'b11;
        for (int k = 1; k <= 6; k++) tick();
        chk("pre_reset_lock", 8'b01_00_00_00);
        i_reset_n = 1'b0;
        #1;
        chk("async_reset", 8'b00_00_00_00);
        tick();
        tick();
        chk("in_reset", 8'b00_00_00_00);
        i_reset_n = 1'b1;
        tick();
        tick();
        chk("rdb_t2", 8'b00_00_00_00);
        tick();
        chk("rdb_t3", 8'b01_00_00_00);
        tick();
        chk("rdb_t4", 8'b01_01_00_00);
        tick();
        chk("rdb_t5", 8'b01_00_00_00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
